// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing unit: fetches one word per instruction, issues it,
// waits for the datapath, then computes the next PC (jumps, BSR/RET via a 4-deep return stack).
module fetch_unit (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RUN,
    output logic        IMEM_REQ,
    output logic [10:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [17:0] IMEM_DATA,
    output logic [7:0]  OPCODE,
    output logic [4:0]  Ri,
    output logic [4:0]  Rj,
    output logic        INSTR_VALID,
    input  logic        EXEC_DONE,
    input  logic        ZERO,
    input  logic        W15,
    input  logic        CY,
    output logic [10:0] PC,
    output logic        STACK_ERR
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, EXEC} state_t;

    state_t            state_q, state_d;
    logic [10:0]       pc_q, pc_d;
    logic [17:0]       ir_q, ir_d;
    logic              req_q, req_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0][10:0]  stk_q, stk_d;

    logic [7:0]  op;
    logic [10:0] pc_inc, pc_abs, pc_rel;
    logic [1:0]  push_idx, pop_idx;

    always_comb begin
        op       = ir_q[17:10];
        pc_inc   = pc_q + 11'd1;
        pc_abs   = {op[2:0], ir_q[7:0]};
        pc_rel   = pc_q + {{3{ir_q[7]}}, ir_q[7:0]};
        // A push onto a full stack lands on the top entry (index 3).
        push_idx = cnt_q[2] ? 2'd3 : cnt_q[1:0];
        pop_idx  = cnt_q[1:0] - 2'd1;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        req_d   = req_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        stk_d   = stk_q;
        case (state_q)
            IDLE: begin
                if (RUN) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
            end
            FETCH: begin
                if (IMEM_ACK) begin
                    ir_d    = IMEM_DATA;
                    req_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = EXEC;
            EXEC: begin
                if (EXEC_DONE) begin
                    state_d = RUN ? FETCH : IDLE;
                    req_d   = RUN;
                    pc_d    = pc_inc;
                    if (op[7:3] == 5'b00100) begin
                        pc_d = pc_abs;
                    end else if (op[7:3] == 5'b00101) begin
                        if (ZERO) pc_d = pc_abs;
                    end else if (op[7:3] == 5'b00110) begin
                        if (!W15) pc_d = pc_abs;
                    end else if (op[7:3] == 5'b00111) begin
                        if (CY) pc_d = pc_abs;
                    end else if (op[7:2] == 6'b000111) begin
                        stk_d[push_idx] = pc_q;
                        pc_d            = pc_rel;
                        if (cnt_q == 3'd4) err_d = 1'b1;
                        else               cnt_d = cnt_q + 3'd1;
                    end else if (op == 8'h41) begin
                        // Empty-stack RET falls through as a NOP (pc_inc).
                        if (cnt_q == 3'd0) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                            pc_d  = stk_q[pop_idx] + 11'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            stk_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            stk_q   <= stk_d;
        end
    end

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign OPCODE      = ir_q[17:10];
    assign Ri          = ir_q[9:5];
    assign Rj          = ir_q[4:0];
    assign INSTR_VALID = vld_q;
    assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instruction-level model (PC, IR, return-stack queue)
// compared every cycle, plus literal expectations at key points.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        RUN = 1'b0;
    logic        IMEM_REQ;
    logic [10:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [17:0] IMEM_DATA = '0;
    logic [7:0]  OPCODE;
    logic [4:0]  Ri, Rj;
    logic        INSTR_VALID;
    logic        EXEC_DONE = 1'b0;
    logic        ZERO = 1'b0, W15 = 1'b0, CY = 1'b0;
    logic [10:0] PC;
    logic        STACK_ERR;

    fetch_unit dut (
        .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .OPCODE(OPCODE), .Ri(Ri), .Rj(Rj), .INSTR_VALID(INSTR_VALID),
        .EXEC_DONE(EXEC_DONE), .ZERO(ZERO), .W15(W15), .CY(CY),
        .PC(PC), .STACK_ERR(STACK_ERR)
    );

    always #5 CLK = ~CLK;

    int errs = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model state: what the outputs must show after the most recent edge.
    int          m_pc;
    logic [17:0] m_ir;
    bit          m_req, m_iv, m_err;
    int          stk[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("req",   32'(IMEM_REQ),    32'(m_req));
            chk("addr",  32'(IMEM_ADDR),   32'(m_pc));
            chk("pc",    32'(PC),          32'(m_pc));
            chk("ivld",  32'(INSTR_VALID), 32'(m_iv));
            chk("opc",   32'(OPCODE),      32'(m_ir[17:10]));
            chk("ri",    32'(Ri),          32'(m_ir[9:5]));
            chk("rj",    32'(Rj),          32'(m_ir[4:0]));
            chk("serr",  32'(STACK_ERR),   32'(m_err));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic m_reset();
        m_pc = 0; m_ir = '0; m_req = 0; m_iv = 0; m_err = 0;
        stk.delete();
    endtask

    function automatic void m_exec(input logic [17:0] w, input bit z, input bit w15, input bit cy);
        int op = int'(w[17:10]);
        int wi = int'(w);
        int x  = (op % 8) * 256 + (wi % 256);
        int s  = wi % 256;
        int nxt = (m_pc + 1) % 2048;
        if (s >= 128) s -= 256;
        if (op / 8 == 4) nxt = x;
        else if (op / 8 == 5) begin if (z) nxt = x; end
        else if (op / 8 == 6) begin if (!w15) nxt = x; end
        else if (op / 8 == 7) begin if (cy) nxt = x; end
        else if (op / 4 == 7) begin
            if (stk.size() == 4) begin stk[3] = m_pc; m_err = 1; end
            else stk.push_back(m_pc);
            nxt = (m_pc + s + 2048) % 2048;
        end else if (op == 65) begin
            if (stk.size() == 0) m_err = 1;
            else nxt = (stk.pop_back() + 1) % 2048;
        end
        m_pc = nxt;
    endfunction

    // Entered with the DUT in FETCH; stray ACK/DONE/RUN activity is injected where it must be ignored.
    task automatic do_instr(input logic [17:0] w, input int waits, input bit z, input bit w15,
                            input bit cy, input int ewaits, input bit run_next);
        for (int i = 0; i < waits; i++) begin
            IMEM_ACK = 0; EXEC_DONE = 1; RUN = i[0];
            step();
        end
        IMEM_ACK = 1; IMEM_DATA = w; EXEC_DONE = 0;
        step();
        m_ir = w; m_req = 0; m_iv = 1;
        IMEM_ACK = 1; IMEM_DATA = 18'h3FFFF; EXEC_DONE = 1;
        step();
        m_iv = 0;
        for (int i = 0; i < ewaits; i++) begin
            EXEC_DONE = 0; IMEM_ACK = 1; RUN = i[0];
            step();
        end
        EXEC_DONE = 1; IMEM_ACK = 0; ZERO = z; W15 = w15; CY = cy; RUN = run_next;
        step();
        EXEC_DONE = 0;
        m_exec(w, z, w15, cy);
        m_req = run_next;
    endtask

    task automatic restart();
        RUN = 1;
        step();
        m_req = 1;
    endtask

    initial begin
        m_reset();
        RESET_N = 0; RUN = 0;
        step();
        chk_en = 1;
        step();
        chk("rst_pc",   32'(PC), 32'h0);
        chk("rst_req",  32'(IMEM_REQ), 32'h0);
        chk("rst_opc",  32'(OPCODE), 32'h0);
        chk("rst_serr", 32'(STACK_ERR), 32'h0);

        RESET_N = 1;
        step(); step();
        restart();
        chk("first_addr", 32'(IMEM_ADDR), 32'h0);

        // MOV W,Rj with two wait cycles
        do_instr(18'h00802, 2, 0, 0, 0, 1, 1);
        chk("mov_pc",  32'(PC), 32'h1);
        chk("mov_opc", 32'(OPCODE), 32'h02);
        chk("mov_rj",  32'(Rj), 32'h2);

        for (int i = 0; i < 4; i++) do_instr(18'h00000 + 18'(i), i % 2, 0, 0, 0, i, 1);
        chk("pc5", 32'(PC), 32'h5);
        do_instr(18'h08C33, 0, 0, 0, 0, 0, 1);
        chk("jmp_addr", 32'(IMEM_ADDR), 32'h333);

        do_instr(18'h0A010, 1, 0, 0, 0, 0, 1);
        chk("jze_nt", 32'(PC), 32'h334);
        do_instr(18'h0A010, 0, 1, 0, 0, 2, 0);
        chk("jze_t", 32'(PC), 32'h010);
        step(); step();
        restart();
        do_instr(18'h0C055, 0, 0, 1, 0, 0, 1);
        chk("jne_nt", 32'(PC), 32'h011);
        do_instr(18'h0EC23, 1, 0, 0, 1, 1, 1);
        chk("jcy_t", 32'(PC), 32'h323);

        do_instr(18'h09CFF, 0, 0, 0, 0, 0, 1);
        chk("pc7ff", 32'(PC), 32'h7FF);
        do_instr(18'h07002, 0, 0, 0, 0, 0, 1);
        chk("bsr_wrap", 32'(PC), 32'h001);
        do_instr(18'h10400, 0, 0, 0, 0, 0, 1);
        chk("ret_wrap", 32'(PC), 32'h000);
        chk("ret_serr", 32'(STACK_ERR), 32'h0);

        // Five nested BSRs; the fifth overwrites the top entry.
        do_instr(18'h07001, 0, 0, 0, 0, 0, 1);
        do_instr(18'h070FE, 0, 0, 0, 0, 0, 1);
        do_instr(18'h07003, 0, 0, 0, 0, 0, 1);
        do_instr(18'h07001, 0, 0, 0, 0, 0, 1);
        chk("bsr4_serr", 32'(STACK_ERR), 32'h0);
        do_instr(18'h07001, 1, 0, 0, 0, 0, 1);
        chk("bsr5_serr", 32'(STACK_ERR), 32'h1);
        chk("bsr5_pc",   32'(PC), 32'h004);
        do_instr(18'h10400, 0, 0, 0, 0, 0, 1);
        chk("ret_top", 32'(PC), 32'h004);
        for (int i = 0; i < 3; i++) do_instr(18'h10400, 0, 0, 0, 0, 1, 1);
        chk("ret_last", 32'(PC), 32'h001);
        do_instr(18'h10400, 0, 0, 0, 0, 0, 1);
        chk("ret_empty_pc",   32'(PC), 32'h002);
        chk("ret_empty_serr", 32'(STACK_ERR), 32'h1);

        // Reset during FETCH with an ACK arriving on the same edge
        IMEM_ACK = 0;
        step();
        RESET_N = 0; IMEM_ACK = 1; IMEM_DATA = 18'h08C33; RUN = 0;
        step();
        m_reset();
        chk("rst_f_req",  32'(IMEM_REQ), 32'h0);
        chk("rst_f_pc",   32'(PC), 32'h0);
        chk("rst_f_iv",   32'(INSTR_VALID), 32'h0);
        chk("rst_f_serr", 32'(STACK_ERR), 32'h0);
        RESET_N = 1;
        step(); step();
        IMEM_ACK = 0;
        restart();
        do_instr(18'h00802, 0, 0, 0, 0, 0, 1);
        chk("post_rst_pc", 32'(PC), 32'h1);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
